// File: rtl/keypad_scan_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_fsm_pkg
// Description : Shared types, default sizes and helper functions for the
//               matrix-keypad scanner.
//               - scan_state_t : scanner state encoding
//               - cnt_width()  : register width needed to hold 0..terminal
//               - lowest_zero_idx() : index of the lowest 0 bit in a vector
// Revision    : 1.0  initial release
// ============================================================================
package keypad_scan_fsm_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    localparam int c_DEF_NROWS        = 4;
    localparam int c_DEF_NCOLS        = 4;
    localparam int c_DEF_SETTLE_CYC   = 4;
    localparam int c_DEF_DEBOUNCE_CYC = 20;
    localparam int c_DEF_RPT_DLY      = 5000;
    localparam int c_DEF_RPT_PER      = 1000;

    // Widest column vector the index helper can search.
    localparam int c_MAX_LINES = 64;

    // Bits needed for a counter running 0..terminal; a terminal of 0 still
    // needs one bit of storage.
    function automatic int cnt_width(input int terminal);
        return (terminal < 1) ? 1 : $clog2(terminal + 1);
    endfunction

    // Lowest-index 0 bit wins; callers pad unused upper bits with 1.
    function automatic int lowest_zero_idx(input logic [c_MAX_LINES-1:0] v);
        int idx;
        idx = 0;
        for (int i = c_MAX_LINES - 1; i >= 0; i--) begin
            if (!v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_fsm_if
// Description : Keypad matrix and key-event bundle.
//               cols_sync : synchronised column sense, 0 = pressed
//               rows      : row drive, one bit low while scanning
//               key_valid : one-cycle key accepted pulse
//               key_row   : row index of accepted key
//               key_col   : column index of accepted key
//               key_held  : key accepted and not yet released
//               key_multi : more than one column low in the held row
//               master = scanner side, slave = matrix / consumer side.
// Revision    : 1.0  initial release
// ============================================================================
interface keypad_scan_fsm_if #(
    parameter int NROWS = 4,
    parameter int NCOLS = 4
) ();
    localparam int c_RW = $clog2(NROWS);
    localparam int c_CW = $clog2(NCOLS);

    logic [NCOLS-1:0] cols_sync;
    logic [NROWS-1:0] rows;
    logic             key_valid;
    logic [c_RW-1:0]  key_row;
    logic [c_CW-1:0]  key_col;
    logic             key_held;
    logic             key_multi;

    modport master (
        input  cols_sync,
        output rows, key_valid, key_row, key_col, key_held, key_multi
    );

    modport slave (
        output cols_sync,
        input  rows, key_valid, key_row, key_col, key_held, key_multi
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scan_fsm_timer.sv
`default_nettype none
// ============================================================================
// Module      : keypad_timer
// Description : Saturating up-counter with synchronous clear, count enable
//               and a run-time terminal value.
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   clr_i    in   clear count to 0 (priority over enable)
//   en_i     in   count up while below terminal
//   term_i   in   terminal value
//   tc_o     out  count has reached terminal
// Revision    : 1.0  initial release
// ============================================================================
module keypad_timer
    import keypad_scan_fsm_pkg::*;
#(
    parameter int MAX_CNT = 1,
    parameter int WIDTH   = cnt_width(MAX_CNT)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;

    // Holding at both the run-time terminal and the build-time maximum keeps
    // the count from ever wrapping inside a state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !tc_o && (cnt_q != WIDTH'(MAX_CNT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (cnt_q >= term_i);

endmodule
`default_nettype wire

// File: rtl/keypad_scan_fsm.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_fsm
// Description : Parametrised matrix-keypad scanner. Drives one row low at a
//               time, samples the synchronised columns, debounces press and
//               release, and reports the accepted key with a one-cycle event.
//   clk       in   clock, all state on posedge
//   reset_n   in   asynchronous active-low reset
//   bus       if   keypad_scan_fsm_if.master (cols_sync in; rows and key_*
//                  outputs, all registered)
// Build option: KEYPAD_AUTOREPEAT_EN adds RPT_DLY / RPT_PER and re-pulses
//               key_valid while a key stays held.
// Revision    : 1.0  initial release
// ============================================================================
module keypad_scan_fsm
    import keypad_scan_fsm_pkg::*;
#(
    parameter int NROWS        = c_DEF_NROWS,
    parameter int NCOLS        = c_DEF_NCOLS,
    parameter int SETTLE_CYC   = c_DEF_SETTLE_CYC,
    parameter int DEBOUNCE_CYC = c_DEF_DEBOUNCE_CYC
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int RPT_DLY      = c_DEF_RPT_DLY,
    parameter int RPT_PER      = c_DEF_RPT_PER
`endif
) (
    input  logic            clk,
    input  logic            reset_n,
    keypad_scan_fsm_if.master bus
);

    localparam int c_RW = $clog2(NROWS);
    localparam int c_CW = $clog2(NCOLS);
    localparam int c_SW = cnt_width(SETTLE_CYC - 1);
    localparam int c_DW = cnt_width(DEBOUNCE_CYC);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    scan_state_t      state_q,    state_d;
    logic [c_RW-1:0]  row_idx_q,  row_idx_d;   // scanned / candidate / held row
    logic [c_CW-1:0]  cand_col_q, cand_col_d;  // candidate / held column
    logic [NROWS-1:0] rows_q,     rows_d;
    logic             valid_q,    valid_d;
    logic [c_RW-1:0]  key_row_q,  key_row_d;
    logic [c_CW-1:0]  key_col_q,  key_col_d;
    logic             held_q,     held_d;
    logic             multi_q,    multi_d;
    // Low for the first cycle out of reset, when rows is still all-ones and
    // no row has actually been driven yet.
    logic             run_q;

    // ------------------------------------------------------------------
    // Timer controls and column decode
    // ------------------------------------------------------------------
    logic                   settle_clr, settle_en, settle_tc;
    logic                   db_clr, db_en, db_tc;
    logic [c_MAX_LINES-1:0] cols_pad;
    logic                   any_low;
    logic                   cand_low;
    logic [c_CW-1:0]        low_idx;
    logic [c_RW-1:0]        next_row;

    always_comb begin
        cols_pad              = '1;
        cols_pad[NCOLS-1:0]   = bus.cols_sync;
    end

    assign any_low  = ~(&bus.cols_sync);
    assign cand_low = ~bus.cols_sync[cand_col_q];
    assign low_idx  = c_CW'(lowest_zero_idx(cols_pad));
    assign next_row = (row_idx_q == c_RW'(NROWS - 1)) ? '0 : row_idx_q + 1'b1;

    keypad_timer #(
        .MAX_CNT (SETTLE_CYC - 1),
        .WIDTH   (c_SW)
    ) u_settle_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (settle_clr),
        .en_i    (settle_en),
        .term_i  (c_SW'(SETTLE_CYC - 1)),
        .tc_o    (settle_tc)
    );

    // Shared between press debounce and release debounce; the two never
    // overlap and the count is cleared on every state change.
    keypad_timer #(
        .MAX_CNT (DEBOUNCE_CYC),
        .WIDTH   (c_DW)
    ) u_debounce_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (db_clr),
        .en_i    (db_en),
        .term_i  (c_DW'(DEBOUNCE_CYC)),
        .tc_o    (db_tc)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int c_RPT_MAX = ((RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER) - 1;
    localparam int c_PW      = cnt_width(c_RPT_MAX);

    logic            rpt_first_q, rpt_first_d;  // waiting for the initial delay
    logic            rpt_clr, rpt_en, rpt_tc;
    logic [c_PW-1:0] rpt_term;

    // Terminal is one short of the interval because the pulse is registered.
    assign rpt_term = rpt_first_q ? c_PW'(RPT_DLY - 1) : c_PW'(RPT_PER - 1);

    keypad_timer #(
        .MAX_CNT (c_RPT_MAX),
        .WIDTH   (c_PW)
    ) u_repeat_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (rpt_clr),
        .en_i    (rpt_en),
        .term_i  (rpt_term),
        .tc_o    (rpt_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_first_q <= 1'b0;
        end else begin
            rpt_first_q <= rpt_first_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        cand_col_d = cand_col_q;
        valid_d    = 1'b0;
        key_row_d  = key_row_q;
        key_col_d  = key_col_q;
        held_d     = held_q;
        multi_d    = multi_q;
        settle_clr = 1'b1;
        settle_en  = 1'b0;
        db_clr     = 1'b1;
        db_en      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_clr     = 1'b1;
        rpt_en      = 1'b0;
        rpt_first_d = rpt_first_q;
`endif

        case (state_q)
            SCAN: begin
                settle_clr = 1'b0;
                settle_en  = run_q;
                if (run_q && settle_tc) begin
                    settle_clr = 1'b1;
                    if (any_low) begin
                        state_d    = DEBOUNCE;
                        cand_col_d = low_idx;
                    end else begin
                        row_idx_d  = next_row;
                    end
                end
            end

            DEBOUNCE: begin
                if (db_tc) begin
                    state_d   = HELD;
                    valid_d   = 1'b1;
                    key_row_d = row_idx_q;
                    key_col_d = cand_col_q;
                    held_d    = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rpt_first_d = 1'b1;
`endif
                end else if (cand_low) begin
                    db_clr = 1'b0;
                    db_en  = 1'b1;
                end else begin
                    // Bounce: drop the candidate and carry on from the next row.
                    state_d   = SCAN;
                    row_idx_d = next_row;
                end
            end

            HELD: begin
                if (db_tc) begin
                    state_d   = SCAN;
                    row_idx_d = next_row;
                    held_d    = 1'b0;
                    multi_d   = 1'b0;
                end else begin
                    // Release count restarts on any low sample of the held column.
                    db_clr  = cand_low;
                    db_en   = ~cand_low;
                    multi_d = ($countones(~bus.cols_sync) > 1);
`ifdef KEYPAD_AUTOREPEAT_EN
                    rpt_clr = 1'b0;
                    rpt_en  = 1'b1;
                    // No repeat while the column already reads released.
                    if (rpt_tc && cand_low) begin
                        valid_d     = 1'b1;
                        rpt_clr     = 1'b1;
                        rpt_first_d = 1'b0;
                    end
`endif
                end
            end

            default: begin
                state_d = SCAN;
            end
        endcase

        rows_d = ~(NROWS'(1) << row_idx_d);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SCAN;
            row_idx_q  <= '0;
            cand_col_q <= '0;
            rows_q     <= '1;
            valid_q    <= 1'b0;
            key_row_q  <= '0;
            key_col_q  <= '0;
            held_q     <= 1'b0;
            multi_q    <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            cand_col_q <= cand_col_d;
            rows_q     <= rows_d;
            valid_q    <= valid_d;
            key_row_q  <= key_row_d;
            key_col_q  <= key_col_d;
            held_q     <= held_d;
            multi_q    <= multi_d;
            run_q      <= 1'b1;
        end
    end

    assign bus.rows      = rows_q;
    assign bus.key_valid = valid_q;
    assign bus.key_row   = key_row_q;
    assign bus.key_col   = key_col_q;
    assign bus.key_held  = held_q;
    assign bus.key_multi = multi_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_keypad_scan_fsm
// Description : Directed self-checking bench for keypad_scan_fsm (4x4,
//               SETTLE_CYC=4, DEBOUNCE_CYC=20). A small key-matrix model
//               pulls a column low while its pressed key's row is driven.
//               Build with KEYPAD_AUTOREPEAT_EN to add the repeat scenario
//               (RPT_DLY=50, RPT_PER=10).
// Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_scan_fsm;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int c_T2_PULSES = 3;
`else
    localparam int c_T2_PULSES = 1;
`endif

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] key_map = '0;   // bit r*4+c = key (r,c) pressed

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    keypad_scan_fsm_if #(.NROWS(4), .NCOLS(4)) kp_if ();

    keypad_scan_fsm #(
        .NROWS        (4),
        .NCOLS        (4),
        .SETTLE_CYC   (4),
        .DEBOUNCE_CYC (20)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .RPT_DLY      (50),
        .RPT_PER      (10)
`endif
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (kp_if.master)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key shorts its column to the driven (low) row.
    always_comb begin
        kp_if.cols_sync = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_map[r*4 + c] && !kp_if.rows[r]) kp_if.cols_sync[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, counting key_valid pulses.
    task automatic run(input int n);
        repeat (n) begin
            tick();
            if (kp_if.key_valid) pulses++;
        end
    endtask

    // Leaves reset deasserted just after an edge; the next edge is cycle 1.
    task automatic do_reset();
        key_map = '0;
        reset_n = 1'b0;
        tick(); tick(); tick();
        reset_n = 1'b1;
        pulses  = 0;
    endtask

    int          first;
    logic [1:0]  got_row, got_col;
    logic        got_held, got_multi;
    logic [3:0]  exp_rows;
    logic        exp_valid;

    initial begin
        // ---------------- reset state ----------------
        key_map = '0;
        reset_n = 1'b0;
        tick(); tick();
        check("rst_rows",  kp_if.rows,      4'hF);
        check("rst_valid", kp_if.key_valid, 0);
        check("rst_row",   kp_if.key_row,   0);
        check("rst_col",   kp_if.key_col,   0);
        check("rst_held",  kp_if.key_held,  0);
        check("rst_multi", kp_if.key_multi, 0);

        // ---------------- 1: idle scan ----------------
        do_reset();
        for (int t = 1; t <= 64; t++) begin
            run(1);
            exp_rows = ~(4'b0001 << (((t - 1) / 4) % 4));
            check($sformatf("idle_rows_t%0d", t), kp_if.rows, exp_rows);
        end
        check("idle_no_valid", pulses, 0);

        // ---------------- 2: clean press row2/col1 ----------------
        do_reset();
        key_map[2*4 + 1] = 1'b1;
        first = 0; got_row = '0; got_col = '0; got_held = 1'b0; got_multi = 1'b1;
        for (int t = 1; t <= 100; t++) begin
            run(1);
            if (kp_if.key_valid && first == 0) begin
                first    = t;
                got_row  = kp_if.key_row;
                got_col  = kp_if.key_col;
                got_held = kp_if.key_held;
            end
            if (t == 50) got_multi = kp_if.key_multi;
        end
        check("t2_valid_cycle", first, 34);
        check("t2_key_row",     got_row, 2);
        check("t2_key_col",     got_col, 1);
        check("t2_held_at_acc", got_held, 1);
        check("t2_multi",       got_multi, 0);
        key_map = '0;
        run(20);
        check("t2_held_rel20",  kp_if.key_held, 1);
        run(1);
        check("t2_held_rel21",  kp_if.key_held, 0);
        check("t2_next_row",    kp_if.rows, 4'b0111);
        check("t2_pulses",      pulses, c_T2_PULSES);

        // ---------------- 3: bounce rejected ----------------
        do_reset();
        run(8);
        key_map[2*4 + 1] = 1'b1;
        run(10);
        key_map = '0;
        run(1);
        check("t3_resume_row3", kp_if.rows, 4'b0111);
        key_map[2*4 + 1] = 1'b1;
        run(10);
        key_map = '0;
        check("t3_rows_t29",    kp_if.rows, 4'b1101);
        run(60);
        check("t3_no_valid",    pulses, 0);
        check("t3_not_held",    kp_if.key_held, 0);

        // ---------------- 4: two keys in row1 ----------------
        do_reset();
        key_map[1*4 + 0] = 1'b1;
        key_map[1*4 + 3] = 1'b1;
        first = 0;
        for (int t = 1; t <= 60; t++) begin
            run(1);
            if (kp_if.key_valid && first == 0) first = t;
            if (t == 40) begin
                got_row   = kp_if.key_row;
                got_col   = kp_if.key_col;
                got_multi = kp_if.key_multi;
                got_held  = kp_if.key_held;
            end
        end
        check("t4_valid_cycle", first, 30);
        check("t4_key_row",     got_row, 1);
        check("t4_key_col",     got_col, 0);
        check("t4_multi_held",  got_multi, 1);
        check("t4_held",        got_held, 1);
        key_map = '0;
        run(21);
        check("t4_held_rel",    kp_if.key_held, 0);
        check("t4_multi_rel",   kp_if.key_multi, 0);

        // ---------------- 5: reset mid-debounce ----------------
        do_reset();
        key_map[0*4 + 2] = 1'b1;
        run(15);
        reset_n = 1'b0;
        #1;
        check("t5_rst_rows",  kp_if.rows,      4'hF);
        check("t5_rst_valid", kp_if.key_valid, 0);
        check("t5_rst_held",  kp_if.key_held,  0);
        check("t5_rst_row",   kp_if.key_row,   0);
        check("t5_rst_col",   kp_if.key_col,   0);
        check("t5_rst_multi", kp_if.key_multi, 0);
        key_map = '0;
        tick(); tick();
        reset_n = 1'b1;
        pulses  = 0;
        run(1);
        check("t5_restart_row0", kp_if.rows, 4'b1110);
        run(60);
        check("t5_no_event",     pulses, 0);

`ifdef KEYPAD_AUTOREPEAT_EN
        // ---------------- 6: auto-repeat ----------------
        do_reset();
        key_map[2*4 + 1] = 1'b1;
        for (int t = 1; t <= 170; t++) begin
            run(1);
            exp_valid = (t == 34) || (t >= 84 && t <= 134 && ((t - 84) % 10) == 0);
            check($sformatf("t6_valid_t%0d", t), kp_if.key_valid, exp_valid);
            if (t == 134) key_map = '0;
        end
        check("t6_key_col", kp_if.key_col, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
